reg_adder: RTL and testbench
============================

// Module: reg_adder
// PURPOSE
//  Registered unsigned adder: sums two NUM-bit operands and presents the full
//  NUM+1-bit result (carry included) one clock after the operands are sampled.
//  Small datapath leaf for arithmetic pipelines that need a clean registered
//  boundary. No handshake; operands are sampled every cycle.
// PARAMETERS
//  NUM    8    operand width in bits (legal: 1..64); result width is NUM+1
// PORTS
//  clk_i  in   1      single clock; all state updates on rising edge
//  rst_i  in   1      reset, synchronous, active-low (0 = reset), sampled on rising clk_i
//  i1     in   NUM    operand A, unsigned
//  i2     in   NUM    operand B, unsigned
//  out    out  NUM+1  registered sum i1+i2; MSB is carry-out
// BEHAVIOUR
//  - Single clock domain clk_i. Reset is synchronous and active-low; no asynchronous
//    paths.
//  - Reset: on a rising edge with rst_i==0, out <= 0. Reset has priority over data.
//    out holds 0 for every cycle that rst_i stays low.
//  - Normal operation (rst_i==1): on each rising edge, out <= {1'b0,i1} + {1'b0,i2}.
//  - Latency: exactly 1 cycle. Operands present at edge k appear on out after edge k.
//    No input registers; throughput is one sum per cycle.
//  - Width rule: unsigned, zero-extended to NUM+1 bits. The result never wraps;
//    max = 2*(2^NUM-1), with carry in out[NUM].
//  - out changes only on the rising clk_i. Input changes between edges are not
//    visible until the next edge; no combinational path from i1/i2 to out.
//  - Reset mid-stream: the first edge with rst_i==0 forces out=0 regardless of the
//    operands. The first edge after rst_i returns to 1 captures the current operands.
//  - Power-up value before the first reset edge is undefined; the bench must apply
//    reset for at least 1 cycle.
//  - X/Z on operands propagates to out; no sanitising.
// TESTING
//  1. Reset: rst_i=0 for 2 edges, i1=8'hFF, i2=8'hFF -> out==9'h000 after each edge.
//  2. Basic add: rst_i=1, i1=8'd24, i2=8'd129 -> out==9'd153 one edge later.
//     out is still the old value before that edge.
//  3. Carry and max: i1=8'hFF, i2=8'hFF -> out==9'h1FE.
//     i1=8'h80, i2=8'h80 -> out==9'h100.
//  4. Zero and identity: i1=0, i2=0 -> out==0. i1=8'h5A, i2=0 -> out==9'h05A.
//  5. Back-to-back: change operands every cycle (3+4, 10+20, 255+1) ->
//     out==7, 30, 256 on consecutive edges. Each result lags its operands by 1.
//  6. Mid-stream reset: with i1=100, i2=50 steady, drop rst_i for 1 edge -> out==0.
//     Release rst_i -> out==150 on the next edge.
//     Then randomise 100 pairs and compare against a reference model with 1-cycle delay.

Source files
------------

// File: rtl/reg_adder.sv
// Registered unsigned adder: full-width sum (carry in MSB) presented one clock
// after the operands are sampled, with no combinational path from inputs to out.
`timescale 1ns/1ps

module reg_adder #(
    parameter int NUM = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NUM-1:0] i1,
    input  logic [NUM-1:0] i2,
    output logic [NUM:0]   out
);

    // Zero-extend both operands first so the carry lands in the top bit
    // instead of being lost to wraparound.
    function automatic logic [NUM:0] add_zext(
        input logic [NUM-1:0] a,
        input logic [NUM-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [NUM:0] sum_s;
    logic [NUM:0] sum_r;

    // Next-state sum from the current operands.
    always_comb begin
        sum_s = add_zext(i1, i2);
    end

    // Output register; a low reset overrides whatever operands are present.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sum_r <= {(NUM+1){1'b0}};
        end else begin
            sum_r <= sum_s;
        end
    end

    assign out = sum_r;

endmodule

// File: tb/tb_reg_adder.sv
// Directed and random checks of reg_adder with NUM=8: reset, carry, latency,
// back-to-back operands and mid-stream reset.
`timescale 1ns/1ps

module tb_reg_adder;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] i1;
    logic [7:0] i2;
    logic [8:0] out;

    int checks;
    int errors;

    reg_adder #(.NUM(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i1    (i1),
        .i2    (i2),
        .out   (out)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive inputs on the falling edge, away from the sampling edge.
    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk_i);
        rst_i = r;
        i1    = a;
        i2    = b;
    endtask

    // Advance past one rising edge and sample shortly after it.
    task automatic tick_check(input string tag, input logic [8:0] expected);
        @(posedge clk_i);
        #1;
        check(tag, out, expected);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] rexp;

        checks = 0;
        errors = 0;
        rst_i  = 1'b0;
        i1     = 8'h00;
        i2     = 8'h00;

        // Reset held for two edges with max operands present.
        apply(1'b0, 8'hFF, 8'hFF);
        tick_check("reset_edge1", 9'h000);
        tick_check("reset_edge2", 9'h000);

        // Basic add; output must hold the old value until the edge.
        apply(1'b1, 8'd24, 8'd129);
        #1;
        check("basic_before_edge", out, 9'h000);
        tick_check("basic_add", 9'd153);

        // Carry and maximum.
        apply(1'b1, 8'hFF, 8'hFF);
        tick_check("max_sum", 9'h1FE);
        apply(1'b1, 8'h80, 8'h80);
        tick_check("carry_only", 9'h100);

        // Zero and identity.
        apply(1'b1, 8'h00, 8'h00);
        tick_check("zero", 9'h000);
        apply(1'b1, 8'h5A, 8'h00);
        tick_check("identity", 9'h05A);

        // Back-to-back operands on consecutive edges.
        apply(1'b1, 8'd3, 8'd4);
        tick_check("b2b_0", 9'd7);
        apply(1'b1, 8'd10, 8'd20);
        tick_check("b2b_1", 9'd30);
        apply(1'b1, 8'd255, 8'd1);
        tick_check("b2b_2", 9'd256);

        // Mid-stream reset with steady operands.
        apply(1'b1, 8'd100, 8'd50);
        tick_check("pre_reset", 9'd150);
        apply(1'b0, 8'd100, 8'd50);
        tick_check("mid_reset", 9'h000);
        apply(1'b1, 8'd100, 8'd50);
        tick_check("post_reset", 9'd150);

        // Random pairs against a zero-extended reference sum, one cycle late.
        for (int n = 0; n < 100; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rexp = {1'b0, ra} + {1'b0, rb};
            apply(1'b1, ra, rb);
            tick_check("random", rexp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
